// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding,
// a constant clog2 helper and the default NUM_REQ / DATA_W values.
package shared_reg_arb_pkg;

    // EMPTY: holding register has no unconsumed word; FULL: it has one.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 32;

    // Number of bits needed to index n items (n >= 2 gives at least 1).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// modulo N, and returns the first set bit as a one-hot grant plus its index.
module rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    // First requester at or after ptr (circularly) wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter feeding one shared holding register with a
// valid/ack handshake toward a downstream consumer. A new word can be
// captured in the same cycle the old one is acked (no bubble).
// Optional requester lock is enabled by defining SHARED_REG_ARB_LOCK_EN.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int DATA_W  = DEF_DATA_W,
    localparam int IW      = clog2(NUM_REQ)
) (
    input  logic                      CLK,
    input  logic                      RES,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_D,
`ifdef SHARED_REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        LOCK,
`endif
    output logic [NUM_REQ-1:0]        GNT,
    output logic [DATA_W-1:0]         Q,
    output logic                      Q_VALID,
    output logic [IW-1:0]             Q_OWNER,
    input  logic                      Q_ACK
);

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       ptr_nxt;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                can_grant;
    logic                capture;
    logic [DATA_W-1:0]   req_data [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_data[i] = REQ_D[i*DATA_W +: DATA_W];
    end

    // A grant may be issued when the register is empty or being drained now.
    assign can_grant = (state == EMPTY) || Q_ACK;
    assign capture   = can_grant && pick_any;
    assign GNT       = (can_grant && !RES) ? pick_gnt : '0;
    assign Q_VALID   = (state == FULL);

`ifdef SHARED_REG_ARB_LOCK_EN
    logic          lock_vld;
    logic [IW-1:0] lock_idx;
    logic          lock_hold;

    // The lock only restricts eligibility while its owner keeps requesting.
    assign lock_hold = lock_vld && REQ[lock_idx];
    assign elig      = lock_hold ? (REQ & (NUM_REQ'(1) << lock_idx)) : REQ;
    assign ptr_nxt   = LOCK[pick_idx] ? pick_idx :
                       (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Lock bookkeeping: set or cleared on every capture, dropped when the
    // owner withdraws its request in a cycle that could have granted.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (capture) begin
            lock_vld <= LOCK[pick_idx];
            lock_idx <= pick_idx;
        end else if (can_grant && lock_vld && !REQ[lock_idx]) begin
            lock_vld <= 1'b0;
        end
    end
`else
    assign elig    = REQ;
    assign ptr_nxt = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (elig),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Holding register FSM: capture on grant, drain on ack, hold otherwise.
    always_ff @(posedge CLK or posedge RES) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RES) begin
            state   <= EMPTY;
            Q       <= '0;
            Q_OWNER <= '0;
            ptr     <= '0;
        end else if (capture) begin
            state   <= FULL;
            Q       <= req_data[pick_idx];
            Q_OWNER <= pick_idx;
            ptr     <= ptr_nxt;
        end else if ((state == FULL) && Q_ACK) begin
            state   <= EMPTY;
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (default configuration,
// NUM_REQ=4, DATA_W=32). Directed steps followed by random traffic, all
// compared against a behavioural model of the holding register.
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            res = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_d = '0;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   q;
    logic            q_valid;
    logic [1:0]      q_owner;
    logic            q_ack = 1'b0;
`ifdef SHARED_REG_ARB_LOCK_EN
    logic [N-1:0]    lock = '0;
`endif

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    bit          m_valid = 1'b0;
    logic [31:0] m_q = '0;
    int          m_owner = 0;
    int          m_ptr = 0;

    shared_reg_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .CLK     (clk),
        .RES     (res),
        .REQ     (req),
        .REQ_D   (req_d),
`ifdef SHARED_REG_ARB_LOCK_EN
        .LOCK    (lock),
`endif
        .GNT     (gnt),
        .Q       (q),
        .Q_VALID (q_valid),
        .Q_OWNER (q_owner),
        .Q_ACK   (q_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Winner index by the round-robin rule, or -1 when nobody requests.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (((r >> ((p + k) % N)) & 4'd1) != 4'd0) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] word_of(input logic [N*DW-1:0] d, input int w);
        logic [N*DW-1:0] t;
        t = d >> (w * DW);
        return t[31:0];
    endfunction

    function automatic logic [N*DW-1:0] index_data();
        logic [N*DW-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 32'(i);
        return d;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_q     = '0;
        m_owner = 0;
        m_ptr   = 0;
    endtask

    // One clock cycle: drive inputs (called just after a falling edge),
    // check the combinational grant, then check registered outputs after
    // the rising edge and return at the following falling edge.
    task automatic do_cycle(input logic [N-1:0] r, input logic a, input logic [N*DW-1:0] d);
        int          w;
        logic [31:0] eg;
        req   = r;
        q_ack = a;
        req_d = d;
        w  = (!m_valid || a) ? model_pick(r, m_ptr) : -1;
        eg = (w >= 0) ? (32'd1 << w) : 32'd0;
        #1;
        chk("gnt", 32'(gnt), eg);
        @(posedge clk);
        if (w >= 0) begin
            m_q     = word_of(d, w);
            m_owner = w;
            m_ptr   = (w + 1) % N;
            m_valid = 1'b1;
        end else if (m_valid && a) begin
            m_valid = 1'b0;
        end
        #1;
        chk("q_valid", 32'(q_valid), 32'(m_valid));
        chk("q_owner", 32'(q_owner), 32'(m_owner));
        chk("q", q, m_q);
        @(negedge clk);
    endtask

    initial begin
        logic [N*DW-1:0] d;
        int              exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};

        // Reset values
        #1;
        chk("rst_q", q, 32'h0);
        chk("rst_valid", 32'(q_valid), 32'h0);
        chk("rst_owner", 32'(q_owner), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        res = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) do_cycle('0, 1'b0, '0);

        // Single requester 2
        d = '0;
        d[2*DW +: DW] = 32'h12345678;
        do_cycle(4'b0100, 1'b0, d);
        chk("single_owner", 32'(q_owner), 32'd2);
        chk("single_q", q, 32'h12345678);

        // Backpressure: full, no ack, everybody requests
        d = index_data();
        for (int i = 0; i < 5; i++) do_cycle(4'b1111, 1'b0, d);
        chk("bp_q_hold", q, 32'h12345678);
        do_cycle(4'b1111, 1'b1, d);
        chk("bp_one_capture", 32'(q_owner), 32'd3);

        // Round-robin with zero-bubble acks
        for (int i = 0; i < 5; i++) begin
            do_cycle(4'b1111, 1'b1, d);
            chk("rr_owner", 32'(q_owner), 32'(exp_seq[i]));
            chk("rr_valid", 32'(q_valid), 32'h1);
        end

        // Drain, then ack while empty
        do_cycle('0, 1'b1, d);
        chk("drain_valid", 32'(q_valid), 32'h0);
        do_cycle('0, 1'b1, d);
        chk("drain_idle", 32'(q_valid), 32'h0);

        // Asynchronous reset while full with 0xDEADBEEF
        d = '0;
        d[0 +: DW] = 32'hDEADBEEF;
        do_cycle(4'b0001, 1'b0, d);
        chk("full_before_rst", q, 32'hDEADBEEF);
        req   = 4'b1111;
        q_ack = 1'b0;
        #2;
        res = 1'b1;
        #1;
        chk("arst_q", q, 32'h0);
        chk("arst_valid", 32'(q_valid), 32'h0);
        chk("arst_gnt", 32'(gnt), 32'h0);
        model_reset();
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle('0, 1'b0, '0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++) d[j*DW +: DW] = $urandom;
            do_cycle(N'($urandom), ($urandom_range(0, 3) != 0), d);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
